// File: rtl/riscv_core.sv
// Single-cycle RV32I + MUL core with private instruction and data memories.
// One instruction retires per rising clk edge; rst is asynchronous active-high.

module rv_pc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] curr_pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) curr_pc <= '0;
        else     curr_pc <= next_pc;
    end
endmodule

module rv_register #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);
    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
endmodule

module rv_inst_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
);
    logic [XLEN-1:0] regs [0:DEPTH-1];
    logic            unused_pc_bits;

    // Loader port; normally tied off and the array is preloaded from outside.
    always_ff @(posedge clk) begin
        if (load_en) regs[load_addr] <= load_data;
    end

    assign inst           = regs[pc[AW+1:2]];
    assign unused_pc_bits = ^{pc[XLEN-1:AW+2], pc[1:0]};
endmodule

module rv_data_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [XLEN/8-1:0] be,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);
    logic [XLEN-1:0] regs [0:DEPTH-1];
    logic [AW-1:0]   idx;
    logic            unused_addr_bits;

    assign idx              = addr[AW+1:2];
    assign rdata            = regs[idx];
    assign unused_addr_bits = ^{addr[XLEN-1:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (be[b]) regs[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

module riscv_core #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam int         IAW        = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] curr_pc, next_pc, pc_plus4, inst;
    logic [XLEN-1:0] rs1_data, rs2_data, rd_data;
    logic [XLEN-1:0] dmem_addr, dmem_rdata, dmem_wdata;
    logic [3:0]      dmem_be;
    logic            rd_we, dmem_we, branch_taken;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]      lane_shift;
    logic [15:0]     load_lane;

    rv_pc #(.XLEN(XLEN)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .next_pc (next_pc),
        .curr_pc (curr_pc)
    );

    rv_inst_mem #(.XLEN(XLEN), .DEPTH(IMEM_DEPTH)) u_inst_mem (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ({IAW{1'b0}}),
        .load_data ({XLEN{1'b0}}),
        .pc        (curr_pc),
        .inst      (inst)
    );

    rv_register #(.XLEN(XLEN)) u_register (
        .clk      (clk),
        .rst      (rst),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_data),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    // Stores are suppressed while reset is held so an aborted instruction leaves memory intact.
    rv_data_mem #(.XLEN(XLEN), .DEPTH(DMEM_DEPTH)) u_data_mem (
        .clk   (clk),
        .we    (dmem_we & ~rst),
        .be    (dmem_be),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign pc_plus4   = curr_pc + XLEN'(4);
    assign dmem_addr  = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign lane_shift = {dmem_addr[1:0], 3'b000};
    assign load_lane  = 16'(dmem_rdata >> lane_shift);

    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (f3)
            3'b000: r = alt ? (a - b) : (a + b);
            3'b001: r = a << b[4:0];
            3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = (rs1_data == rs2_data);
            3'b001: branch_taken = (rs1_data != rs2_data);
            3'b100: branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110: branch_taken = (rs1_data <  rs2_data);
            3'b111: branch_taken = (rs1_data >= rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    // Any encoding not matched below falls through as a NOP: no writes, pc+4.
    always_comb begin
        next_pc    = pc_plus4;
        rd_we      = 1'b0;
        rd_data    = '0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        case (opcode)
            OPC_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OPC_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = curr_pc + imm_u;
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = curr_pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = pc_plus4;
                    next_pc = (rs1_data + imm_i) & ~XLEN'(1);
                end
            end
            OPC_BRANCH: begin
                if (branch_taken) next_pc = curr_pc + imm_b;
            end
            OPC_LOAD: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_data = {{(XLEN-8){load_lane[7]}}, load_lane[7:0]};
                    3'b001:  rd_data = {{(XLEN-16){load_lane[15]}}, load_lane};
                    3'b010:  rd_data = dmem_rdata;
                    3'b100:  rd_data = {{(XLEN-8){1'b0}}, load_lane[7:0]};
                    3'b101:  rd_data = {{(XLEN-16){1'b0}}, load_lane};
                    default: rd_we   = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dmem_wdata = rs2_data << lane_shift;
                case (funct3)
                    3'b000: begin
                        dmem_we = 1'b1;
                        dmem_be = 4'b0001 << dmem_addr[1:0];
                    end
                    3'b001: begin
                        dmem_we = 1'b1;
                        dmem_be = 4'b0011 << dmem_addr[1:0];
                    end
                    3'b010: begin
                        dmem_we    = 1'b1;
                        dmem_be    = 4'b1111;
                        dmem_wdata = rs2_data;
                    end
                    default: dmem_we = 1'b0;
                endcase
            end
            OPC_IMM: begin
                if (funct3 == 3'b001) begin
                    rd_we = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    rd_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end else begin
                    rd_we = 1'b1;
                end
                rd_data = alu(funct3, (funct3 == 3'b101) && inst[30], rs1_data, imm_i);
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
                    rd_we   = (funct3 == 3'b000);
                    rd_data = rs1_data * rs2_data;
                end else begin
                    rd_we   = (funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                    rd_data = alu(funct3, inst[30], rs1_data, rs2_data);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_riscv_core.sv
// Self-checking bench for riscv_core: table of small programs with expected
// architectural state, scoreboard queue, plus a hand-written mid-program reset sequence.

module tb_riscv_core;
    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_core #(.XLEN(32), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OPI     = 7'b0010011;
    localparam logic [6:0]  OPR     = 7'b0110011;
    localparam logic [6:0]  LDO     = 7'b0000011;
    localparam logic [6:0]  LUIO    = 7'b0110111;
    localparam logic [6:0]  JALRO   = 7'b1100111;
    localparam int          SEL_PC  = 32;
    localparam int          SEL_MEM = 64;
    localparam int          NV      = 8;

    typedef struct {
        string       name;
        logic [31:0] prog [8];
        int          n_prog;
        int          cycles;
        int          n_chk;
        int          sel [4];
        logic [31:0] exp [4];
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    vec_t vecs [NV];
    chk_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] u_t(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] probe(input int sel);
        int w;
        if (sel == SEL_PC) return dut.u_pc.curr_pc;
        if (sel >= SEL_MEM) begin
            w = sel - SEL_MEM;
            return dut.u_data_mem.regs[w[9:0]];
        end
        return dut.u_register.regs[sel[4:0]];
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] e);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic drain();
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            act = probe(c.sel);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s (sel %0d): got %h, expected %h", c.name, c.sel, act, c.exp);
            end
        end
    endtask

    task automatic set_prog(input int t, input int k, input logic [31:0] w);
        vecs[t].prog[k] = w;
        vecs[t].n_prog  = k + 1;
    endtask

    task automatic set_chk(input int t, input int k, input int sel, input logic [31:0] e);
        vecs[t].sel[k] = sel;
        vecs[t].exp[k] = e;
        vecs[t].n_chk  = k + 1;
    endtask

    task automatic load_imem(input int t);
        for (int i = 0; i < 1024; i++) dut.u_inst_mem.regs[10'(i)] = NOP;
        for (int i = 0; i < vecs[t].n_prog; i++) dut.u_inst_mem.regs[10'(i)] = vecs[t].prog[i];
    endtask

    task automatic run_vec(input int t);
        @(negedge clk);
        rst = 1'b1;
        load_imem(t);
        for (int k = 0; k < vecs[t].n_chk; k++) push(vecs[t].name, vecs[t].sel[k], vecs[t].exp[k]);
        @(negedge clk);
        rst = 1'b0;
        repeat (vecs[t].cycles) @(negedge clk);
        drain();
    endtask

    initial begin
        vecs[0].name = "addi"; vecs[0].cycles = 2;
        set_prog(0, 0, i_t(5, 0, 0, 1, OPI));
        set_prog(0, 1, i_t(-7, 1, 0, 2, OPI));
        set_chk(0, 0, 1, 32'h0000_0005);
        set_chk(0, 1, 2, 32'hFFFF_FFFE);
        set_chk(0, 2, SEL_PC, 32'd8);

        vecs[1].name = "lui_sw_lb_lhu"; vecs[1].cycles = 5;
        set_prog(1, 0, u_t(32'h12345, 3, LUIO));
        set_prog(1, 1, i_t(32'h678, 3, 0, 3, OPI));
        set_prog(1, 2, s_t(8, 3, 0, 2));
        set_prog(1, 3, i_t(9, 0, 0, 4, LDO));
        set_prog(1, 4, i_t(10, 0, 5, 5, LDO));
        set_chk(1, 0, 3, 32'h1234_5678);
        set_chk(1, 1, 4, 32'h0000_0056);
        set_chk(1, 2, 5, 32'h0000_1234);
        set_chk(1, 3, SEL_PC, 32'd20);

        vecs[2].name = "bne_loop"; vecs[2].cycles = 7;
        set_prog(2, 0, i_t(3, 0, 0, 1, OPI));
        set_prog(2, 1, i_t(-1, 1, 0, 1, OPI));
        set_prog(2, 2, b_t(-4, 0, 1, 1));
        set_chk(2, 0, 1, 32'd0);
        set_chk(2, 1, SEL_PC, 32'd12);

        vecs[3].name = "jal_jalr"; vecs[3].cycles = 2;
        set_prog(3, 0, j_t(8, 1));
        set_prog(3, 1, NOP);
        set_prog(3, 2, i_t(5, 1, 0, 2, JALRO));
        set_chk(3, 0, 1, 32'd4);
        set_chk(3, 1, 2, 32'd12);
        set_chk(3, 2, SEL_PC, 32'd8);

        vecs[4].name = "mul_sra_x0"; vecs[4].cycles = 5;
        set_prog(4, 0, i_t(-3, 0, 0, 6, OPI));
        set_prog(4, 1, i_t(7, 0, 0, 7, OPI));
        set_prog(4, 2, r_t(1, 7, 6, 0, 8));
        set_prog(4, 3, r_t(32'h20, 7, 6, 5, 9));
        set_prog(4, 4, i_t(1, 0, 0, 0, OPI));
        set_chk(4, 0, 8, 32'hFFFF_FFEB);
        set_chk(4, 1, 9, 32'hFFFF_FFFF);
        set_chk(4, 2, 0, 32'd0);
        set_chk(4, 3, SEL_PC, 32'd20);

        vecs[5].name = "slt_srli_sub"; vecs[5].cycles = 5;
        set_prog(5, 0, i_t(-1, 0, 0, 1, OPI));
        set_prog(5, 1, r_t(0, 1, 0, 3, 2));
        set_prog(5, 2, r_t(0, 0, 1, 2, 3));
        set_prog(5, 3, i_t(28, 1, 5, 4, OPI));
        set_prog(5, 4, r_t(32'h20, 1, 0, 0, 5));
        set_chk(5, 0, 2, 32'd1);
        set_chk(5, 1, 3, 32'd1);
        set_chk(5, 2, 4, 32'h0000_000F);
        set_chk(5, 3, 5, 32'd1);

        vecs[6].name = "blt_bgeu"; vecs[6].cycles = 5;
        set_prog(6, 0, i_t(-2, 0, 0, 1, OPI));
        set_prog(6, 1, i_t(1, 0, 0, 2, OPI));
        set_prog(6, 2, b_t(8, 2, 1, 4));
        set_prog(6, 3, i_t(99, 0, 0, 3, OPI));
        set_prog(6, 4, b_t(8, 2, 1, 7));
        set_prog(6, 5, i_t(77, 0, 0, 4, OPI));
        set_prog(6, 6, i_t(7, 0, 0, 5, OPI));
        set_chk(6, 0, 3, 32'd0);
        set_chk(6, 1, 4, 32'd0);
        set_chk(6, 2, 5, 32'd7);
        set_chk(6, 3, SEL_PC, 32'd28);

        vecs[7].name = "lh_lb_sb_lw"; vecs[7].cycles = 7;
        set_prog(7, 0, u_t(32'h8badf, 1, LUIO));
        set_prog(7, 1, i_t(32'h00d, 1, 0, 1, OPI));
        set_prog(7, 2, s_t(16, 1, 0, 2));
        set_prog(7, 3, i_t(18, 0, 1, 2, LDO));
        set_prog(7, 4, i_t(16, 0, 0, 3, LDO));
        set_prog(7, 5, s_t(17, 1, 0, 0));
        set_prog(7, 6, i_t(16, 0, 2, 4, LDO));
        set_chk(7, 0, 2, 32'hFFFF_8BAD);
        set_chk(7, 1, 3, 32'h0000_000D);
        set_chk(7, 2, 4, 32'h8BAD_0D0D);
        set_chk(7, 3, SEL_PC, 32'd28);

        // Reset state, asynchronous: sampled before any clock edge.
        #2 rst = 1'b1;
        #1;
        push("reset_pc", SEL_PC, 32'd0);
        for (int r = 0; r < 32; r++) push("reset_reg", r, 32'd0);
        drain();

        for (int t = 0; t < NV; t++) run_vec(t);

        // Mid-program reset: sw x0,36(x0); addi x1,x0,0x55; sw x1,36(x0); jal x0,0
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) dut.u_inst_mem.regs[10'(i)] = NOP;
        dut.u_inst_mem.regs[10'd0] = s_t(36, 0, 0, 2);
        dut.u_inst_mem.regs[10'd1] = i_t(32'h55, 0, 0, 1, OPI);
        dut.u_inst_mem.regs[10'd2] = s_t(36, 1, 0, 2);
        dut.u_inst_mem.regs[10'd3] = j_t(0, 0);
        @(negedge clk);
        rst = 1'b0;
        push("pre_rst_mem", SEL_MEM + 9, 32'h0000_0055);
        push("pre_rst_pc", SEL_PC, 32'd12);
        push("pre_rst_x1", 1, 32'h0000_0055);
        repeat (3) @(negedge clk);
        drain();

        #2 rst = 1'b1;
        #1;
        push("mid_rst_pc", SEL_PC, 32'd0);
        for (int r = 0; r < 32; r++) push("mid_rst_reg", r, 32'd0);
        drain();

        repeat (2) @(negedge clk);
        push("rst_no_store", SEL_MEM + 9, 32'h0000_0055);
        push("rst_hold_pc", SEL_PC, 32'd0);
        drain();

        rst = 1'b0;
        @(negedge clk);
        push("restart_pc", SEL_PC, 32'd4);
        push("restart_store", SEL_MEM + 9, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
